// File: rtl/adc_lane_deskew_cal.sv
// Per-lane IDELAY calibration: sweeps every tap on all lanes against a known ADC
// test pattern, tracks the longest error-free tap run per lane and loads its centre.
module adc_lane_deskew_cal #(
    parameter int NUM_LANES     = 8,
    parameter int TAP_BITS      = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 256,
    parameter int MIN_EYE       = 4
) (
    input  logic                              clock_in,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [NUM_LANES-1:0]              data_rise,
    input  logic [NUM_LANES-1:0]              data_fall,
    input  logic [NUM_LANES-1:0]              exp_rise,
    input  logic [NUM_LANES-1:0]              exp_fall,
    output logic [NUM_LANES-1:0]              delay_ld,
    output logic [NUM_LANES*TAP_BITS-1:0]     delay_wdata,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_LANES-1:0]              lane_fail,
    output logic [NUM_LANES*(TAP_BITS+1)-1:0] lane_eye
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_UPDATE, S_APPLY, S_DONE
    } state_t;

    state_t                              state;
    logic [TAP_BITS-1:0]                 tap;
    logic [TAP_BITS-1:0]                 nxt_tap;
    logic [CNT_W-1:0]                    cnt;
    logic [NUM_LANES-1:0]                err;
    logic [NUM_LANES-1:0]                mism;
    logic [NUM_LANES-1:0][TAP_BITS:0]    cur_len, best_len, nxt_cur_len, nxt_best_len;
    logic [NUM_LANES-1:0][TAP_BITS-1:0]  cur_start, best_start, nxt_cur_start, nxt_best_start;
    logic [NUM_LANES*TAP_BITS-1:0]       apply_wdata;
    logic [NUM_LANES-1:0]                apply_fail;
    logic [NUM_LANES*(TAP_BITS+1)-1:0]   apply_eye;

    assign mism    = (data_rise ^ exp_rise) | (data_fall ^ exp_fall);
    assign nxt_tap = tap + 1'b1;

    // Run tracking for the UPDATE step; the final tap closes the open run so the
    // APPLY values can be registered straight from these results.
    always_comb begin
        logic [TAP_BITS:0]   cand_len;
        logic [TAP_BITS-1:0] cand_start;
        logic [TAP_BITS:0]   half;
        cand_len       = '0;
        cand_start     = '0;
        half           = '0;
        nxt_cur_len    = cur_len;
        nxt_cur_start  = cur_start;
        nxt_best_len   = best_len;
        nxt_best_start = best_start;
        apply_wdata    = '0;
        apply_fail     = '0;
        apply_eye      = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand_len   = cur_len[i];
            cand_start = cur_start[i];
            if (!err[i]) begin
                cand_len = cur_len[i] + 1'b1;
                if (cur_len[i] == '0) cand_start = tap;
            end
            if (err[i] || tap == TAP_MAX) begin
                if (cand_len > best_len[i]) begin
                    nxt_best_len[i]   = cand_len;
                    nxt_best_start[i] = cand_start;
                end
                nxt_cur_len[i] = '0;
            end else begin
                nxt_cur_len[i]   = cand_len;
                nxt_cur_start[i] = cand_start;
            end
            half          = (nxt_best_len[i] - 1'b1) >> 1;
            apply_fail[i] = nxt_best_len[i] < (TAP_BITS+1)'(MIN_EYE);
            apply_wdata[i*TAP_BITS +: TAP_BITS] =
                apply_fail[i] ? '0 : nxt_best_start[i] + half[TAP_BITS-1:0];
            apply_eye[i*(TAP_BITS+1) +: (TAP_BITS+1)] = nxt_best_len[i];
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tap         <= '0;
            cnt         <= '0;
            err         <= '0;
            cur_len     <= '0;
            cur_start   <= '0;
            best_len    <= '0;
            best_start  <= '0;
            delay_ld    <= '0;
            delay_wdata <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lane_fail   <= '0;
            lane_eye    <= '0;
        end else begin
            delay_ld <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        tap         <= '0;
                        err         <= '0;
                        cur_len     <= '0;
                        cur_start   <= '0;
                        best_len    <= '0;
                        best_start  <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        delay_ld    <= '1;
                        delay_wdata <= '0;
                        lane_fail   <= '0;
                        lane_eye    <= '0;
                    end
                end
                S_LOAD: begin
                    state <= S_SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                        cnt   <= CNT_W'(CHECK_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    err <= err | mism;
                    if (cnt == '0) state <= S_UPDATE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_UPDATE: begin
                    cur_len    <= nxt_cur_len;
                    cur_start  <= nxt_cur_start;
                    best_len   <= nxt_best_len;
                    best_start <= nxt_best_start;
                    err        <= '0;
                    delay_ld   <= '1;
                    if (tap == TAP_MAX) begin
                        state       <= S_APPLY;
                        delay_wdata <= apply_wdata;
                        lane_fail   <= apply_fail;
                        lane_eye    <= apply_eye;
                    end else begin
                        state       <= S_LOAD;
                        tap         <= nxt_tap;
                        delay_wdata <= {NUM_LANES{nxt_tap}};
                    end
                end
                S_APPLY: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_lane_deskew_cal.sv
// Directed bench: an IDELAY model passes the test pattern only on per-lane tap masks;
// results, latency and load sequencing are checked against hand-computed values.
module tb_adc_lane_deskew_cal;

    localparam int NL = 8;
    localparam int TB = 5;

    logic              clock_in = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic [NL-1:0]     data_rise, data_fall;
    logic [NL-1:0]     exp_rise = 8'hA5;
    logic [NL-1:0]     exp_fall = 8'h3C;
    logic [NL-1:0]     delay_ld;
    logic [NL*TB-1:0]  delay_wdata;
    logic              busy, done;
    logic [NL-1:0]     lane_fail;
    logic [NL*(TB+1)-1:0] lane_eye;

    adc_lane_deskew_cal #(
        .NUM_LANES(8), .TAP_BITS(5), .SETTLE_CYCLES(16), .CHECK_CYCLES(256), .MIN_EYE(4)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .start(start),
        .data_rise(data_rise), .data_fall(data_fall),
        .exp_rise(exp_rise), .exp_fall(exp_fall),
        .delay_ld(delay_ld), .delay_wdata(delay_wdata),
        .busy(busy), .done(done), .lane_fail(lane_fail), .lane_eye(lane_eye)
    );

    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad   = 0;
    logic [31:0] mask [NL];
    logic [TB-1:0] lane_tap [NL];
    logic inj    = 1'b0;
    logic inj_en = 1'b0;
    int load_idx = 0;
    int seq_err  = 0;
    int ld_err   = 0;
    int n;
    int exp_tap [NL];
    int exp_eye [NL];
    logic [NL*TB-1:0]     ew;
    logic [NL*(TB+1)-1:0] ee;

    // IDELAY model: tap takes effect on the clock edge where the load strobe is high
    always @(posedge clock_in) begin
        for (int i = 0; i < NL; i++)
            if (delay_ld[i]) lane_tap[i] <= delay_wdata[i*TB +: TB];
    end

    always_comb begin
        data_rise = ~exp_rise;
        data_fall = ~exp_fall;
        for (int i = 0; i < NL; i++) begin
            if (mask[i][lane_tap[i]] === 1'b1) begin
                data_rise[i] = exp_rise[i];
                data_fall[i] = exp_fall[i];
            end
        end
        if (inj) data_fall[2] = ~data_fall[2];
    end

    always @(negedge clock_in) begin
        if (start && !busy) begin
            load_idx <= 0;
            seq_err  <= 0;
            ld_err   <= 0;
        end else if (delay_ld == 8'hFF) begin
            if (load_idx < 32)
                for (int i = 0; i < NL; i++)
                    if (delay_wdata[i*TB +: TB] != load_idx[TB-1:0]) seq_err <= seq_err + 1;
            load_idx <= load_idx + 1;
        end else if (delay_ld != '0) begin
            ld_err <= ld_err + 1;
        end
    end

    // One corrupted lane-2 sample well inside the CHECK window of tap 15
    always @(negedge clock_in) begin
        if (inj_en && delay_ld == 8'hFF && load_idx == 15) begin
            repeat (116) @(negedge clock_in);
            inj <= 1'b1;
            @(negedge clock_in);
            inj <= 1'b0;
        end
    end

    function automatic logic [31:0] rng(input int a, input int b);
        logic [31:0] m;
        m = '0;
        for (int t = 0; t < 32; t++) if (t >= a && t <= b) m[t] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_start();
        @(posedge clock_in); #1 start = 1'b1;
        @(posedge clock_in); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at, input int stop_at, output int cnt);
        cnt = 0;
        while (!done && cnt < 10000 && cnt != stop_at) begin
            @(posedge clock_in); #1;
            cnt++;
            start = (cnt == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic set_mixed();
        mask[0] = rng(2, 5) | rng(20, 31);
        mask[1] = 32'hFFFF_FFFF;
        mask[2] = rng(10, 20);
        mask[3] = rng(0, 3) | rng(8, 11);
        mask[4] = rng(7, 8);
        for (int i = 5; i < NL; i++) mask[i] = rng(10, 20);
        exp_tap = '{25, 15, 12, 1, 0, 15, 15, 15};
        exp_eye = '{12, 32, 5, 4, 2, 11, 11, 11};
    endtask

    task automatic check_results(input string tag, input logic [NL-1:0] efail);
        for (int i = 0; i < NL; i++) begin
            ew[i*TB +: TB]         = exp_tap[i][TB-1:0];
            ee[i*(TB+1) +: (TB+1)] = exp_eye[i][TB:0];
        end
        chk({tag, "_latency"}, 64'(n), 64'd8769);
        chk({tag, "_wdata"}, 64'(delay_wdata), 64'(ew));
        chk({tag, "_eye"}, 64'(lane_eye), 64'(ee));
        chk({tag, "_fail"}, 64'(lane_fail), 64'(efail));
        chk({tag, "_flags"}, {61'd0, busy, done, |delay_ld}, 64'b010);
        chk({tag, "_loads"}, 64'(load_idx), 64'd33);
        chk({tag, "_seq"}, 64'(seq_err + ld_err), 64'd0);
    endtask

    initial begin
        #23;
        chk("rst_ctrl", {52'd0, delay_ld, busy, done, lane_fail[1:0]}, 64'd0);
        chk("rst_wdata", 64'(delay_wdata), 64'd0);
        chk("rst_eye_fail", {8'd0, lane_eye, lane_fail}, 64'd0);
        @(negedge clock_in) reset_n = 1'b1;

        // Run 1: all lanes pass taps 10..20
        for (int i = 0; i < NL; i++) mask[i] = rng(10, 20);
        exp_tap = '{15, 15, 15, 15, 15, 15, 15, 15};
        exp_eye = '{11, 11, 11, 11, 11, 11, 11, 11};
        run_start();
        wait_done(-1, -1, n);
        check_results("uniform", 8'h00);

        // Run 2: mixed windows, ties, narrow eye, injected error; start after done clears outputs
        set_mixed();
        inj_en = 1'b1;
        run_start();
        chk("restart_clear", {8'd0, lane_eye, lane_fail}, 64'd0);
        chk("restart_flags", {54'd0, delay_ld, busy, done}, {54'd0, 8'hFF, 1'b1, 1'b0});
        wait_done(-1, -1, n);
        check_results("mixed", 8'h10);

        // Run 3: identical, with a stray start pulse during CHECK of tap 1
        run_start();
        wait_done(500, -1, n);
        check_results("busy_start", 8'h10);

        // Run 4: reset asserted in CHECK of tap 17
        inj_en = 1'b0;
        run_start();
        wait_done(-1, 4758, n);
        chk("abort_tap", 64'(load_idx), 64'd18);
        chk("abort_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ctrl", {54'd0, delay_ld, busy, done}, 64'd0);
        chk("abort_data", {8'd0, lane_eye, lane_fail}, 64'd0);
        chk("abort_wdata", 64'(delay_wdata), 64'd0);
        @(negedge clock_in) reset_n = 1'b1;

        // Run 5: normal completion after the abort
        inj_en = 1'b1;
        run_start();
        wait_done(-1, -1, n);
        check_results("post_abort", 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
